sync_launch: RTL and testbench
==============================

SYNC_LAUNCH -- requirements
Module: sync_launch

Interface
REQ-001 The block SHALL have parameter HOLD_CYCLES, default 4, giving the number of clk_a cycles data_en is held high per launch; legal range 1..256.
REQ-002 The block SHALL have parameter GAP_CYCLES, default 2, giving the minimum number of clk_a cycles data_en is held low after each launch; legal range 0..256.
REQ-003 The block SHALL have port clk_a, input, 1 bit: the single clock; all logic is rising-edge triggered.
REQ-004 The block SHALL have port arstn, input, 1 bit: asynchronous active-low reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit: upstream word available.
REQ-006 The block SHALL have port in_data, input, 4 bits: upstream word.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the block accepts in_data this cycle.
REQ-008 The block SHALL have port data_in, output, 4 bits: registered word driven to the clk_b-side synchronizer.
REQ-009 The block SHALL have port data_en, output, 1 bit: registered launch qualifier driven to the synchronizer.
REQ-010 The block SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-011 The block SHALL implement a three-state machine: IDLE, HOLD, GAP.
REQ-012 The block SHALL drive in_ready high only in IDLE, as a combinational decode of the state register.
REQ-013 The block SHALL accept a word on a rising edge where in_valid && in_ready; at that edge it loads data_in <= in_data, sets data_en to 1, loads the 8-bit counter with HOLD_CYCLES-1 and enters HOLD.
REQ-014 The block SHALL hold data_en high for exactly HOLD_CYCLES consecutive cycles, starting the cycle after acceptance.
REQ-015 In HOLD, the counter SHALL decrement each cycle. When it reaches 0, data_en SHALL clear, and the block SHALL enter GAP with the counter loaded to GAP_CYCLES-1, or enter IDLE directly if GAP_CYCLES == 0.
REQ-016 In GAP, the counter SHALL decrement each cycle. When it reaches 0, the block SHALL enter IDLE.
REQ-017 data_in SHALL remain stable from its load until the next accepted word, including through GAP and IDLE, so the downstream capture never sees it change.
REQ-018 The minimum spacing between successive data_en rising edges SHALL be HOLD_CYCLES + GAP_CYCLES + 1 cycles.
REQ-019 in_valid and in_data SHALL be ignored outside IDLE; no word is lost, because acceptance requires in_ready.
REQ-020 If in_valid is high in the same cycle the block returns to IDLE, the word SHALL be accepted on the following edge, since in_ready derives from the registered state.
REQ-021 The counter SHALL be 8 bits wide, SHALL never wrap below 0, and SHALL be ignored in IDLE.

Reset
REQ-022 On arstn low, the block SHALL asynchronously set state=IDLE, counter=0, data_in=4'h0, data_en=0 and busy=0; in_ready follows as 1.
REQ-023 Reset asserted mid-HOLD or mid-GAP SHALL abort the launch immediately, with data_en low in the same instant.
REQ-024 Deassertion of arstn SHALL be used as-is, with no internal reset synchronizer; the first acceptance is possible on the first rising edge after release.

Configuration
REQ-025 With macro SYNC_LAUNCH_XFER_CNT_EN defined, the block SHALL add output xfer_cnt (8 bits), reset to 0, incremented on every accepted word and wrapping from 255 to 0.
REQ-026 Without SYNC_LAUNCH_XFER_CNT_EN, the xfer_cnt port and its register SHALL not exist, and all other behaviour SHALL be identical.

Verification
REQ-027 Reset, then in_valid=1 with in_data=4'hA at edge N: data_in=4'hA and data_en=1 on cycles N+1..N+4; data_en=0 from N+5; in_ready=0 on N+1..N+6 and 1 at N+7.
REQ-028 in_valid held high with words 4'h1, 4'h2, 4'h3 under the defaults: data_en rising edges exactly 7 cycles apart, data_in values 1, 2, 3 in order, and data_in unchanged between loads.
REQ-029 GAP_CYCLES=0, HOLD_CYCLES=1, continuous in_valid: data_en pulses 1 cycle high, 1 cycle low, and busy toggles accordingly.
REQ-030 Assert arstn low 2 cycles into HOLD with data_in=4'h5: data_en=0 and data_in=4'h0 immediately; after release, word 4'h6 is accepted on the first edge.
REQ-031 Change in_data while busy with in_valid=1: data_in is unaffected until IDLE, then takes the current in_data value.
REQ-032 With SYNC_LAUNCH_XFER_CNT_EN defined, perform 257 accepts: xfer_cnt=1. Without the macro, the bench compiles without the xfer_cnt port.

Source files
------------

// File: rtl/sync_launch.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sync_launch: holds a word + qualifier for a clk_b synchronizer; optional |
// | accepted-word counter via SYNC_LAUNCH_XFER_CNT_EN.  Rev 1.0              |
// +--------------------------------------------------------------------------+
module sync_launch #(
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 2
) (
  input  logic       clk_a,
  input  logic       arstn,
  input  logic       in_valid,
  input  logic [3:0] in_data,
  output logic       in_ready,
  output logic [3:0] data_in,
  output logic       data_en,
`ifdef SYNC_LAUNCH_XFER_CNT_EN
  output logic [7:0] xfer_cnt,
`endif
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);
  localparam logic [7:0] GAP_LOAD  = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;

  state_t     state;
  logic [7:0] cnt;

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  // data_in is only written on acceptance, so it stays put through GAP and IDLE
  always_ff @(posedge clk_a or negedge arstn) begin
    if (!arstn) begin
      state   <= IDLE;
      cnt     <= 8'd0;
      data_in <= 4'h0;
      data_en <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            data_in <= in_data;
            data_en <= 1'b1;
            cnt     <= HOLD_LOAD;
            state   <= HOLD;
          end
        end
        HOLD: begin
          if (cnt == 8'd0) begin
            data_en <= 1'b0;
            if (GAP_CYCLES == 0) begin
              state <= IDLE;
            end else begin
              cnt   <= GAP_LOAD;
              state <= GAP;
            end
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        GAP: begin
          if (cnt == 8'd0) begin
            state <= IDLE;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        default: begin
          data_en <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

`ifdef SYNC_LAUNCH_XFER_CNT_EN
  always_ff @(posedge clk_a or negedge arstn) begin
    if (!arstn) begin
      xfer_cnt <= 8'd0;
    end else if (in_valid && in_ready) begin
      xfer_cnt <= xfer_cnt + 8'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_sync_launch.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_sync_launch: two instances (4/2 and 1/0) against a timeline model.    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_sync_launch;

  logic clk_a = 1'b0;
  always #5 clk_a = ~clk_a;

  logic       arstn;
  logic       va, vb;
  logic [3:0] da, db;
  logic       rdy_a, en_a, busy_a, rdy_b, en_b, busy_b;
  logic [3:0] q_a, q_b;
`ifdef SYNC_LAUNCH_XFER_CNT_EN
  logic [7:0] xc_a, xc_b;
`endif

  int errors = 0;
  int checks = 0;

  sync_launch #(.HOLD_CYCLES(4), .GAP_CYCLES(2)) u_a (
    .clk_a(clk_a), .arstn(arstn), .in_valid(va), .in_data(da),
    .in_ready(rdy_a), .data_in(q_a), .data_en(en_a),
`ifdef SYNC_LAUNCH_XFER_CNT_EN
    .xfer_cnt(xc_a),
`endif
    .busy(busy_a)
  );

  sync_launch #(.HOLD_CYCLES(1), .GAP_CYCLES(0)) u_b (
    .clk_a(clk_a), .arstn(arstn), .in_valid(vb), .in_data(db),
    .in_ready(rdy_b), .data_in(q_b), .data_en(en_b),
`ifdef SYNC_LAUNCH_XFER_CNT_EN
    .xfer_cnt(xc_b),
`endif
    .busy(busy_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Model: age = cycles since the last accepted word (0 = nothing since reset).
  // A launch is high for ages 1..HOLD and the block is busy for ages 1..HOLD+GAP.
  int         age_a, age_b, n_a, n_b;
  logic [3:0] m_a, m_b;

  function automatic logic m_en(input int hold, input int age);
    return (age >= 1) && (age <= hold);
  endfunction

  function automatic logic m_busy(input int hold, input int gap, input int age);
    return (age >= 1) && (age <= hold + gap);
  endfunction

  task automatic m_step(input int hold, input int gap, input logic v, input logic [3:0] d,
                        inout int age, inout logic [3:0] dat, inout int n);
    if (!m_busy(hold, gap, age) && v) begin
      age = 1;
      dat = d;
      n++;
    end else if (age != 0 && age < 1000) begin
      age++;
    end
  endtask

  task automatic model_reset();
    age_a = 0; age_b = 0; n_a = 0; n_b = 0; m_a = 4'h0; m_b = 4'h0;
  endtask

  task automatic check_all();
    check("a_en",    en_a,   m_en(4, age_a));
    check("a_busy",  busy_a, m_busy(4, 2, age_a));
    check("a_ready", rdy_a,  !m_busy(4, 2, age_a));
    check("a_data",  q_a,    m_a);
    check("b_en",    en_b,   m_en(1, age_b));
    check("b_busy",  busy_b, m_busy(1, 0, age_b));
    check("b_ready", rdy_b,  !m_busy(1, 0, age_b));
    check("b_data",  q_b,    m_b);
`ifdef SYNC_LAUNCH_XFER_CNT_EN
    check("a_xfer",  xc_a,   n_a % 256);
    check("b_xfer",  xc_b,   n_b % 256);
`endif
  endtask

  int   cyc = 0;
  int   rises[$];
  logic prev_en_a = 1'b0;

  // Called at a negedge: drive inputs, advance the model at the posedge, check at the next negedge
  task automatic cycle(input logic v_a, input logic [3:0] d_a, input logic v_b, input logic [3:0] d_b);
    va = v_a; da = d_a; vb = v_b; db = d_b;
    @(posedge clk_a);
    if (arstn) begin
      m_step(4, 2, v_a, d_a, age_a, m_a, n_a);
      m_step(1, 0, v_b, d_b, age_b, m_b, n_b);
    end
    @(negedge clk_a);
    cyc++;
    if (en_a && !prev_en_a) rises.push_back(cyc);
    prev_en_a = en_a;
    check_all();
  endtask

  task automatic do_reset();
    arstn = 1'b0;
    va = 1'b0; vb = 1'b0; da = 4'h0; db = 4'h0;
    model_reset();
    @(negedge clk_a);
    check_all();
    arstn = 1'b1;
    prev_en_a = en_a;
  endtask

  initial begin
    logic [3:0] words [3];
    int         k;
    int         guard;

    do_reset();

    // single word 0xA, then idle long enough to see HOLD, GAP and the return to IDLE
    cycle(1'b1, 4'hA, 1'b1, 4'hA);
    check("a_first_data", q_a, 32'hA);
    for (int i = 0; i < 8; i++) cycle(1'b0, 4'h0, 1'b0, 4'h0);

    // continuous valid with words 1,2,3; B sees back-to-back random words
    words[0] = 4'h1; words[1] = 4'h2; words[2] = 4'h3;
    rises.delete();
    k = 0;
    guard = 0;
    while (k < 3 && guard < 40) begin
      cycle(1'b1, words[k], 1'b1, 4'($urandom_range(15)));
      if (age_a == 1) k++;
      guard++;
    end
    check("words_accepted", k, 3);
    for (int i = 0; i < 8; i++) cycle(1'b0, 4'h0, 1'b1, 4'($urandom_range(15)));
    check("rise_count", rises.size(), 3);
    if (rises.size() == 3) begin
      check("rise_gap_1", rises[1] - rises[0], 7);
      check("rise_gap_2", rises[2] - rises[1], 7);
    end

    // reset two cycles into HOLD aborts the launch immediately
    do_reset();
    cycle(1'b1, 4'h5, 1'b1, 4'h5);
    cycle(1'b0, 4'h0, 1'b0, 4'h0);
    cycle(1'b0, 4'h0, 1'b0, 4'h0);
    check("pre_abort_en", en_a, 1);
    #2;
    arstn = 1'b0;
    model_reset();
    #1;
    check("abort_en",    en_a,   0);
    check("abort_data",  q_a,    0);
    check("abort_busy",  busy_a, 0);
    check("abort_ready", rdy_a,  1);
    @(negedge clk_a);
    check_all();
    arstn = 1'b1;
    cycle(1'b1, 4'h6, 1'b0, 4'h0);
    check("post_reset_data", q_a, 32'h6);
    check("post_reset_en",   en_a, 1);

    // in_data churns every cycle while valid stays high
    for (int i = 0; i < 30; i++)
      cycle(1'b1, 4'($urandom_range(15)), 1'b1, 4'($urandom_range(15)));

    // random traffic
    for (int i = 0; i < 400; i++)
      cycle(($urandom_range(9) < 7), 4'($urandom_range(15)),
            ($urandom_range(9) < 5), 4'($urandom_range(15)));

    // 257 accepts on A so the transfer counter wraps once
    do_reset();
    guard = 0;
    while (n_a < 257 && guard < 2000) begin
      cycle(1'b1, 4'($urandom_range(15)), 1'b1, 4'($urandom_range(15)));
      guard++;
    end
    check("accepts_257", n_a, 257);
`ifdef SYNC_LAUNCH_XFER_CNT_EN
    check("xfer_wrap", xc_a, 1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
